// File: rtl/ascon_perm_round_ctrl.sv
// ---------------------------------------------------------------------------
// ascon_perm_round_ctrl
//
// Round sequencer for the iterative ASCON permutation (p^12 / p^8 / p^6).
// A 320-bit state (five 64-bit lanes x0..x4) is loaded on an accepted start.
// One round per clock is then applied by an external round datapath
// (constant addition -> substitution -> linear diffusion). This block owns
// the state register and the round index. It captures each round result and
// pulses done_o once the final round has been captured.
//
// Optional feature macro: ASCON_PERM_BUSY_ERR_EN
//   defined     : err_o pulses for one cycle after any edge that sees
//                 start_i while a permutation is running.
//   not defined : err_o is tied low.
//
// Ports
//   clock_i        in   1        system clock, rising edge
//   resetb_i       in   1        asynchronous active-low reset
//   start_i        in   1        permutation request (accepted in IDLE/DONE)
//   mode_i         in   2        00 p^12, 01 p^8, 10 p^6, 11 runs as p^12
//   state_i        in   5x64     initial state, sampled with an accepted start
//   round_state_i  in   5x64     round datapath result for round_state_o/round_o
//   round_state_o  out  5x64     state register, feeds the round datapath
//   round_o        out  4        round index for constant addition
//   state_o        out  5x64     permutation result (same register)
//   busy_o         out  1        high while rounds are running
//   done_o         out  1        one-cycle pulse, state_o holds the result
//   err_o          out  1        start-while-busy flag (see macro above)
// ---------------------------------------------------------------------------
module ascon_perm_round_ctrl #(
    parameter int ROUND_MAX = 12
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [4:0][63:0] state_i,
    input  logic [4:0][63:0] round_state_i,
    output logic [4:0][63:0] round_state_o,
    output logic [3:0]       round_o,
    output logic [4:0][63:0] state_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUND_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    fsm_t             fsm_q;
    fsm_t             fsm_d;
    logic [3:0]       round_q;
    logic [4:0][63:0] state_q;
    logic             load;
    logic             last_round;

    // Shorter permutations run the tail of the constant table, so the
    // first round index is ROUND_MAX - N. The reserved mode runs the full p^12.
    function automatic logic [3:0] first_round(input logic [1:0] mode);
        case (mode)
            2'b01:   first_round = 4'(ROUND_MAX - 8);
            2'b10:   first_round = 4'(ROUND_MAX - 6);
            default: first_round = 4'(ROUND_MAX - 12);
        endcase
    endfunction

    // A start is only honoured outside RUN. Accepting it in DONE gives
    // back-to-back permutations without an idle bubble.
    assign load       = start_i && (fsm_q != ST_RUN);
    assign last_round = (round_q == LAST_ROUND);

    // ---- FSM state register ----
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // ---- FSM next-state logic ----
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: begin
                if (start_i) begin
                    fsm_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_round) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                fsm_d = start_i ? ST_RUN : ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // ---- State and round registers ----
    // The state register is cleared by reset so that an aborted run leaves
    // no partial result visible.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= '0;
            round_q <= '0;
        end else if (load) begin
            state_q <= state_i;
            round_q <= first_round(mode_i);
        end else if (fsm_q == ST_RUN) begin
            state_q <= round_state_i;
            round_q <= last_round ? 4'd0 : round_q + 4'd1;
        end
    end

    // ---- FSM output logic ----
    always_comb begin
        busy_o  = 1'b0;
        done_o  = 1'b0;
        round_o = '0;
        case (fsm_q)
            ST_RUN: begin
                busy_o  = 1'b1;
                round_o = round_q;
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    assign round_state_o = state_q;
    assign state_o       = state_q;

`ifdef ASCON_PERM_BUSY_ERR_EN
    logic err_q;

    // ---- Busy-error flag register ----
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= start_i && (fsm_q == ST_RUN);
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_perm_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ascon_perm_round_ctrl
//
// Directed bench for ascon_perm_round_ctrl. The round datapath is modelled as
// constant addition only: x2[7:0] ^= round_constant[round_o]. Expected lane-2
// bytes are hand computed. Each adjacent pair of ASCON constants XORs to 0x11,
// so rounds 0..11 give 0x00, rounds 4..11 give 0x00, and rounds 6..11 give 0x11.
// ---------------------------------------------------------------------------
module tb_ascon_perm_round_ctrl;

    logic             clk;
    logic             resetb;
    logic             start_i;
    logic [1:0]       mode_i;
    logic [4:0][63:0] state_i;
    logic [4:0][63:0] round_state_i;
    logic [4:0][63:0] round_state_o;
    logic [3:0]       round_o;
    logic [4:0][63:0] state_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    int checks   = 0;
    int failures = 0;

`ifdef ASCON_PERM_BUSY_ERR_EN
    localparam logic [63:0] EXP_ERR = 64'd1;
`else
    localparam logic [63:0] EXP_ERR = 64'd0;
`endif

    ascon_perm_round_ctrl #(.ROUND_MAX(12)) dut (
        .clock_i       (clk),
        .resetb_i      (resetb),
        .start_i       (start_i),
        .mode_i        (mode_i),
        .state_i       (state_i),
        .round_state_i (round_state_i),
        .round_state_o (round_state_o),
        .round_o       (round_o),
        .state_o       (state_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rc(input logic [3:0] r);
        case (r)
            4'd0:    rc = 8'hf0;
            4'd1:    rc = 8'he1;
            4'd2:    rc = 8'hd2;
            4'd3:    rc = 8'hc3;
            4'd4:    rc = 8'hb4;
            4'd5:    rc = 8'ha5;
            4'd6:    rc = 8'h96;
            4'd7:    rc = 8'h87;
            4'd8:    rc = 8'h78;
            4'd9:    rc = 8'h69;
            4'd10:   rc = 8'h5a;
            4'd11:   rc = 8'h4b;
            default: rc = 8'h00;
        endcase
    endfunction

    // Constant-addition-only round datapath model.
    always_comb begin
        round_state_i          = round_state_o;
        round_state_i[2][7:0]  = round_state_o[2][7:0] ^ rc(round_o);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Starts a run from IDLE or DONE, checks every round index, and returns
    // in the done_o cycle (so the caller may issue a back-to-back start).
    task automatic run_check(input string tag, input logic [1:0] mode,
                             input logic [3:0] first, input int n,
                             input logic [4:0][63:0] init, input logic [63:0] exp_x2);
        start_i = 1'b1;
        mode_i  = mode;
        state_i = init;
        step();
        start_i = 1'b0;
        mode_i  = ~mode;
        state_i = '1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_round"}, 64'(round_o), 64'(first) + 64'(i));
            chk({tag, "_busy"}, 64'(busy_o), 64'd1);
            chk({tag, "_nodone"}, 64'(done_o), 64'd0);
            step();
        end
        chk({tag, "_done"}, 64'(done_o), 64'd1);
        chk({tag, "_done_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done_round"}, 64'(round_o), 64'd0);
        chk({tag, "_x2"}, state_o[2], exp_x2);
        chk({tag, "_x0"}, state_o[0], init[0]);
        chk({tag, "_x4"}, state_o[4], init[4]);
        chk({tag, "_rs_eq"}, round_state_o[2], state_o[2]);
    endtask

    logic [4:0][63:0] zero_st;
    logic [4:0][63:0] pat_st;
    logic             seen_done;

    initial begin
        zero_st = '0;
        pat_st  = {64'h0f1e2d3c4b5a6978, 64'hfedcba9876543210,
                   64'h5555aaaa5555aaaa, 64'hdeadbeefcafef00d,
                   64'h0123456789abcdef};

        // 1. Reset held low with start asserted
        resetb  = 1'b0;
        start_i = 1'b1;
        mode_i  = 2'b00;
        state_i = pat_st;
        step();
        step();
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_round", 64'(round_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        for (int l = 0; l < 5; l++) chk("rst_state", state_o[l], 64'd0);
        start_i = 1'b0;
        resetb  = 1'b1;
        step();
        chk("idle_busy", 64'(busy_o), 64'd0);

        // 2. p^12 from zero state
        run_check("p12", 2'b00, 4'd0, 12, zero_st, 64'h0);
        step();
        chk("p12_after_done", 64'(done_o), 64'd0);
        chk("p12_idle_busy", 64'(busy_o), 64'd0);
        chk("p12_hold_x2", state_o[2], 64'h0);

        // 3. p^6 and p^8 from zero state
        run_check("p6", 2'b10, 4'd6, 6, zero_st, 64'h11);
        step();
        chk("p6_hold_x2", state_o[2], 64'h11);
        run_check("p8", 2'b01, 4'd4, 8, zero_st, 64'h0);
        step();

        // Reserved mode behaves as p^12
        run_check("p11", 2'b11, 4'd0, 12, pat_st, 64'h5555aaaa5555aaaa);
        step();

        // 4. Back-to-back: second start issued in the done_o cycle
        run_check("b2b_a", 2'b10, 4'd6, 6, pat_st, 64'h5555aaaa5555aabb);
        run_check("b2b_b", 2'b10, 4'd6, 6, zero_st, 64'h11);
        step();

        // 5. start pulsed during round 3 of p^12
        start_i = 1'b1;
        mode_i  = 2'b00;
        state_i = zero_st;
        step();
        start_i = 1'b0;
        chk("busy_err_pre", 64'(err_o), 64'd0);
        step();
        step();
        step();
        chk("busy_round3", 64'(round_o), 64'd3);
        start_i = 1'b1;
        mode_i  = 2'b10;
        state_i = pat_st;
        step();
        start_i = 1'b0;
        chk("busy_round4", 64'(round_o), 64'd4);
        chk("busy_err", 64'(err_o), EXP_ERR);
        step();
        chk("busy_round5", 64'(round_o), 64'd5);
        chk("busy_err_clr", 64'(err_o), 64'd0);
        for (int r = 6; r < 12; r++) begin
            step();
            chk("busy_round", 64'(round_o), 64'(r));
            chk("busy_nodone", 64'(done_o), 64'd0);
        end
        step();
        chk("busy_done", 64'(done_o), 64'd1);
        chk("busy_x2", state_o[2], 64'h0);
        chk("busy_x0", state_o[0], 64'h0);
        step();

        // 6. Reset during round 5 of p^12
        start_i = 1'b1;
        mode_i  = 2'b00;
        state_i = zero_st;
        step();
        start_i = 1'b0;
        for (int r = 0; r < 5; r++) step();
        chk("abort_round5", 64'(round_o), 64'd5);
        chk("abort_x2_pre", state_o[2], 64'hb4);
        resetb = 1'b0;
        #1;
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_round", 64'(round_o), 64'd0);
        chk("abort_x2", state_o[2], 64'h0);
        chk("abort_done", 64'(done_o), 64'd0);
        @(posedge clk);
        #1;
        resetb = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 14; c++) begin
            step();
            if (done_o || busy_o) seen_done = 1'b1;
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);
        run_check("restart", 2'b10, 4'd6, 6, pat_st, 64'h5555aaaa5555aabb);
        step();
        chk("restart_idle", 64'(done_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
